// File: rtl/fpr_muldiv_if.sv
// fpr_muldiv_if: request/response bundle between the FPR read/write buses,
// the control path and the iterative multiply/divide unit.
//   start, op[1:0], busA[31:0], busB[31:0]  : request (control/FPR -> unit)
//   busy, done, result, result_hi, dz, err  : response (unit -> control/FPR)
interface fpr_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        dz;
  logic        err;

  modport master (output start, op, busA, busB,
                  input  busy, done, result, result_hi, dz, err);
  modport slave  (input  start, op, busA, busB,
                  output busy, done, result, result_hi, dz, err);
endinterface

// File: rtl/fpr_muldiv.sv
// fpr_muldiv: iterative 32-bit multiply/divide behind the FPR file.
// Radix-2 shift-add multiply or restoring divide over 32 cycles on operand
// magnitudes, with a sign fix in the final cycle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : fpr_muldiv_if.slave (start/op/busA/busB in; busy/done/result/
//           result_hi/dz/err out)
// Optional feature macro: FPR_MULDIV_DIV_EN (divide datapath). Without it,
// divide ops finish one edge after accept with err=1 and zero results.
module fpr_muldiv (
  input  logic        clk,
  input  logic        reset,
  fpr_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      r_state, w_next;
  logic        r_div;        // latched op is a divide
  logic        r_neg_q;      // negate product / quotient
  logic [31:0] r_opnd;       // multiplicand magnitude or divisor magnitude
  logic [63:0] r_acc;        // {hi/remainder, lo/multiplier/quotient}
  logic [4:0]  r_cnt;
`ifdef FPR_MULDIV_DIV_EN
  logic [31:0] r_a;          // raw dividend, returned as-is on divide by zero
  logic        r_neg_r;      // remainder takes sign of dividend
  logic [32:0] w_shl, w_trial;
`endif

  logic        w_signed, w_skip;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_msum;
  logic [63:0] w_step, w_prod;

  assign w_signed = ~bus.op[0];
  // 0x80000000 negates to itself, which is its correct unsigned magnitude
  assign w_mag_a  = (w_signed && bus.busA[31]) ? (~bus.busA + 32'd1) : bus.busA;
  assign w_mag_b  = (w_signed && bus.busB[31]) ? (~bus.busB + 32'd1) : bus.busB;

`ifdef FPR_MULDIV_DIV_EN
  assign w_skip = 1'b0;
`else
  assign w_skip = bus.op[1];  // no divide hardware: go straight to FIN
`endif

  assign bus.busy = (r_state != S_IDLE);

  // one iteration of the selected algorithm
  always_comb begin
    w_msum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    w_step = {w_msum, r_acc[31:1]};
`ifdef FPR_MULDIV_DIV_EN
    w_shl   = {r_acc[63:32], r_acc[31]};
    w_trial = w_shl - {1'b0, r_opnd};
    // a restore only happens when w_shl < divisor, so w_shl[32] is 0 there
    if (r_div)
      w_step = w_trial[32] ? {w_shl[31:0],   r_acc[30:0], 1'b0}
                           : {w_trial[31:0], r_acc[30:0], 1'b1};
`endif
  end

  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_skip ? S_FIN : S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div         <= 1'b0;
      r_neg_q       <= 1'b0;
      r_opnd        <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.dz        <= 1'b0;
      bus.err       <= 1'b0;
`ifdef FPR_MULDIV_DIV_EN
      r_a           <= '0;
      r_neg_r       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_div   <= bus.op[1];
          r_neg_q <= w_signed & (bus.busA[31] ^ bus.busB[31]);
          r_cnt   <= '0;
          bus.dz  <= 1'b0;
          bus.err <= 1'b0;
          if (bus.op[1]) begin
            r_opnd <= w_mag_b;
            r_acc  <= {32'd0, w_mag_a};
          end else begin
            r_opnd <= w_mag_a;
            r_acc  <= {32'd0, w_mag_b};
          end
`ifdef FPR_MULDIV_DIV_EN
          r_a     <= bus.busA;
          r_neg_r <= w_signed & bus.busA[31];
`endif
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIN: begin
          bus.done <= 1'b1;
          if (!r_div) begin
            bus.result    <= w_prod[31:0];
            bus.result_hi <= w_prod[63:32];
          end
`ifdef FPR_MULDIV_DIV_EN
          else if (r_opnd == 32'd0) begin
            bus.result    <= '1;
            bus.result_hi <= r_a;
            bus.dz        <= 1'b1;
          end else begin
            bus.result    <= r_neg_q ? (~r_acc[31:0] + 32'd1)  : r_acc[31:0];
            bus.result_hi <= r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
          end
`else
          else begin
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.err       <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpr_muldiv.sv
// tb_fpr_muldiv: scoreboard bench for fpr_muldiv. Expected results come from
// a behavioural arithmetic model, are queued at issue and popped at done.
module tb_fpr_muldiv;
  logic clk = 1'b0;
  logic reset = 1'b0;
  fpr_muldiv_if bus();
  fpr_muldiv dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        dz;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.done === 1'b1) n_done <= n_done + 1;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.hi = '0; e.dz = 1'b0; e.err = 1'b0; e.lat = 33;
    case (op)
      2'b00: begin p = sa * sb; e.res = p[31:0]; e.hi = p[63:32]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; e.hi = p[63:32]; end
      default: begin
`ifdef FPR_MULDIV_DIV_EN
        if (b == 32'd0) begin
          e.res = '1; e.hi = a; e.dz = 1'b1;
        end else if (op == 2'b10) begin
          p = sa / sb; e.res = p[31:0];
          p = sa % sb; e.hi  = p[31:0];
        end else begin
          e.res = a / b; e.hi = a % b;
        end
`else
        e.err = 1'b1; e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int e0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.busA = a; bus.busB = b;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // waits (bounded) for done, then pops and compares the scoreboard entry;
  // returns at the negedge of the done cycle
  task automatic wait_done(input int e0, input string nm);
    exp_t e;
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (bus.done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    e = sbq.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s timeout: no done within 80 cycles", nm);
    end else begin
      n_cmp++; if (cyc - e0 !== e.lat) begin n_bad++;
        $display("FAIL %s latency: got %0d want %0d", nm, cyc - e0, e.lat); end
      n_cmp++; if (bus.result !== e.res) begin n_bad++;
        $display("FAIL %s result: got %h want %h", nm, bus.result, e.res); end
      n_cmp++; if (bus.result_hi !== e.hi) begin n_bad++;
        $display("FAIL %s result_hi: got %h want %h", nm, bus.result_hi, e.hi); end
      n_cmp++; if (bus.dz !== e.dz) begin n_bad++;
        $display("FAIL %s dz: got %b want %b", nm, bus.dz, e.dz); end
      n_cmp++; if (bus.err !== e.err) begin n_bad++;
        $display("FAIL %s err: got %b want %b", nm, bus.err, e.err); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++;
        $display("FAIL %s busy_at_done: got %b want 0", nm, bus.busy); end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string nm);
    int e0;
    sbq.push_back(model(op, a, b));
    issue(op, a, b, e0);
    wait_done(e0, nm);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.busA = '0; bus.busB = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done, bus.dz, bus.err} !== 4'b0) begin n_bad++;
      $display("FAIL reset flags: got busy/done/dz/err=%b want 0000",
               {bus.busy, bus.done, bus.dz, bus.err}); end
    n_cmp++; if (bus.result !== 32'd0) begin n_bad++;
      $display("FAIL reset result: got %h want 0", bus.result); end
    n_cmp++; if (bus.result_hi !== 32'd0) begin n_bad++;
      $display("FAIL reset result_hi: got %h want 0", bus.result_hi); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, "multu_max_x2");
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, "mult_neg3_x7");
    run_op(2'b00, 32'h80000000, 32'h80000000, "mult_minsq");
    run_op(2'b00, 32'h00000000, 32'h87654321, "mult_zero");
    for (int i = 0; i < 3; i++) begin
      run_op(2'b00, $urandom, $urandom, "mult_rand");
      run_op(2'b01, $urandom, $urandom, "multu_rand");
    end
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, "div_neg7_2");
    run_op(2'b11, 32'd100,      32'd7,        "divu_100_7");
    run_op(2'b11, 32'h12345678, 32'h00000000, "divu_by_zero");
    run_op(2'b10, 32'hFFFFFFF0, 32'h00000000, "div_by_zero_neg");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, "div_7_neg2");
    run_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, "div_neg7_neg2");
    run_op(2'b11, 32'hFFFFFFFF, 32'h00000001, "divu_max_1");
    for (int i = 0; i < 2; i++) begin
      run_op(2'b10, $urandom, $urandom | 32'h1, "div_rand");
      run_op(2'b11, $urandom, $urandom_range(1, 65535), "divu_rand");
    end
  endtask

  task automatic test_busy_ignore();
    int e0, d0;
    sbq.push_back(model(2'b00, 32'h0001E240, 32'hFFFF0001));
    issue(2'b00, 32'h0001E240, 32'hFFFF0001, e0);
    while (cyc < e0 + 4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.busA = 32'hDEADBEEF; bus.busB = 32'h3;
    @(negedge clk);  // start sampled on E5 while running
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++;
      $display("FAIL ignore busy_mid_run: got %b want 1", bus.busy); end
    d0 = n_done;
    wait_done(e0, "ignore_start");
    repeat (45) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 1) begin n_bad++;
      $display("FAIL ignore done_count: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_back_to_back();
    int e0, d;
    logic [31:0] old_res, old_hi;
    sbq.push_back(model(2'b01, 32'h00012345, 32'h00000100));
    issue(2'b01, 32'h00012345, 32'h00000100, e0);
    wait_done(e0, "b2b_first");
    d = cyc;
    old_res = bus.result; old_hi = bus.result_hi;
    sbq.push_back(model(2'b00, 32'hFFFFFF00, 32'h00000300));
    bus.start = 1'b1; bus.op = 2'b00; bus.busA = 32'hFFFFFF00; bus.busB = 32'h00000300;
    @(negedge clk);
    bus.start = 1'b0;
    e0 = d + 1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++;
      $display("FAIL b2b accept: busy got %b want 1", bus.busy); end
    repeat (10) @(negedge clk);
    n_cmp++; if ({bus.result, bus.result_hi} !== {old_res, old_hi}) begin n_bad++;
      $display("FAIL b2b hold: got %h_%h want %h_%h",
               bus.result_hi, bus.result, old_hi, old_res); end
    wait_done(e0, "b2b_second");
    n_cmp++; if (cyc - d !== 34) begin n_bad++;
      $display("FAIL b2b spacing: got %0d want 34", cyc - d); end
  endtask

  task automatic test_reset_mid();
    int e0, d0;
    issue(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, e0);  // discarded, not queued
    while (cyc < e0 + 9) @(negedge clk);
    @(posedge clk);  // E10
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.result, bus.result_hi} !== 64'd0) begin n_bad++;
      $display("FAIL rst_mid results: got %h_%h want 0", bus.result_hi, bus.result); end
    n_cmp++; if ({bus.done, bus.dz, bus.err} !== 3'b0) begin n_bad++;
      $display("FAIL rst_mid flags: got %b want 000", {bus.done, bus.dz, bus.err}); end
    d0 = n_done;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (n_done !== d0) begin n_bad++;
      $display("FAIL rst_mid no_done: got %0d pulses want 0", n_done - d0); end
    run_op(2'b01, 32'h0000FFFF, 32'h0000FFFF, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
